// File: rtl/spdp_mem_panel_if.sv
// Host command/response bus of the SPDP memory panel: a valid/ready command
// port plus the examine data return and run completion flags.
interface spdp_mem_panel_if #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 7
);
    logic              host_valid;
    logic              host_ready;
    logic [1:0]        host_op;
    logic [ADDR_W-1:0] host_addr;
    logic [WORD_W-1:0] host_wdata;
    logic              host_rvalid;
    logic [WORD_W-1:0] host_rdata;
    logic              host_done;
    logic              host_err;

    modport master (
        output host_valid, host_op, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata, host_done, host_err
    );

    modport slave (
        input  host_valid, host_op, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata, host_done, host_err
    );
endinterface

// File: rtl/spdp_mem_panel.sv
// Front-panel memory for a bit-serial CPU: the CPU reads/writes single bits,
// the host examines/deposits whole words and single-steps or runs the CPU.
module spdp_mem_panel #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 7,
    parameter int BA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_ma,
    input  logic [BA_W-1:0]   cpu_ba,
    input  logic              cpu_write,
    input  logic              cpu_mb,
    output logic              cpu_membus,
    input  logic              cpu_halt,
    output logic              cpu_contin,
    spdp_mem_panel_if.slave   host
);
    localparam logic [1:0]        OP_EXAMINE  = 2'b00;
    localparam logic [1:0]        OP_DEPOSIT  = 2'b01;
    localparam logic [1:0]        OP_CONTINUE = 2'b10;
    localparam logic [1:0]        OP_RUN_N    = 2'b11;
    localparam logic [WORD_W-1:0] ONE         = {{(WORD_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] ZERO        = {WORD_W{1'b0}};
    // Timeout fires so that host_done lands eight cycles after the contin cycle.
    localparam logic [2:0]        WDOG_LAST   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_RUN_WAIT = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    logic [WORD_W-1:0] mem [2**ADDR_W];

    state_t            state_r, state_s;
    logic [WORD_W-1:0] remaining_r, remaining_s;
    logic [2:0]        wdog_r, wdog_s;
    logic              contin_r, contin_s;
    logic              rvalid_r, rvalid_s;
    logic [WORD_W-1:0] rdata_r, rdata_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              ready_s;
    logic              accept_s;
    logic              ba_ok_s;

    assign ba_ok_s    = (32'(cpu_ba) < 32'(WORD_W));
    assign cpu_membus = ba_ok_s ? mem[cpu_ma][cpu_ba] : 1'b0;
    assign ready_s    = (state_r == ST_IDLE) && cpu_halt;
    assign accept_s   = host.host_valid && ready_s;

    assign host.host_ready  = ready_s;
    assign host.host_rvalid = rvalid_r;
    assign host.host_rdata  = rdata_r;
    assign host.host_done   = done_r;
    assign host.host_err    = err_r;
    assign cpu_contin       = contin_r;

    // Memory array: host deposits (CPU halted) or CPU bit writes (CPU running).
    always_ff @(posedge clk) begin
        if (accept_s && (host.host_op == OP_DEPOSIT)) begin
            mem[host.host_addr] <= host.host_wdata;
        end else if (cpu_write && !cpu_halt && ba_ok_s) begin
            mem[cpu_ma][cpu_ba] <= cpu_mb;
        end
    end

    // Next-state and next-output logic of the panel controller.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        wdog_s      = wdog_r;
        rvalid_s    = 1'b0;
        rdata_s     = rdata_r;
        done_s      = 1'b0;
        err_s       = err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    err_s = 1'b0;
                    case (host.host_op)
                        OP_EXAMINE: begin
                            rvalid_s = 1'b1;
                            rdata_s  = mem[host.host_addr];
                        end
                        OP_DEPOSIT: begin
                            rvalid_s = 1'b0;
                        end
                        OP_CONTINUE: begin
                            remaining_s = ONE;
                            state_s     = ST_RUN;
                        end
                        OP_RUN_N: begin
                            remaining_s = host.host_wdata;
                            if (host.host_wdata == ZERO) begin
                                done_s = 1'b1;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                wdog_s  = 3'd0;
                state_s = ST_RUN_WAIT;
            end
            ST_RUN_WAIT: begin
                if (!cpu_halt) begin
                    state_s = ST_SETTLE;
                end else if (wdog_r == WDOG_LAST) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    wdog_s = wdog_r + 3'd1;
                end
            end
            ST_SETTLE: begin
                if (cpu_halt) begin
                    remaining_s = remaining_r - ONE;
                    if (remaining_r == ONE) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        contin_s = (state_s == ST_RUN);
    end

    // Controller state and registered outputs; reset leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            remaining_r <= ZERO;
            wdog_r      <= 3'd0;
            contin_r    <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= ZERO;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            wdog_r      <= wdog_s;
            contin_r    <= contin_s;
            rvalid_r    <= rvalid_s;
            rdata_r     <= rdata_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end
endmodule
